// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and parameter limits for the data memory port.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int MEM_DATA_W     = 32;
    localparam int LAT_MIN        = 1;
    localparam int LAT_MAX        = 4;
    localparam int RESP_DEPTH_MIN = 1;
    localparam int RESP_DEPTH_MAX = 8;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t               op;
        logic                  err;
        logic [MEM_DATA_W-1:0] data;
    } mem_resp_t;

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resp_fifo
// Brief    : Circular response FIFO with register-sourced head and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module resp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic             head_valid_out,
    output logic [WIDTH-1:0] head_data_out,
    output logic [CNT_W-1:0] count_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop_in && (count_q != '0);

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_in) begin
            slot_d[wr_ptr_q] = push_data_in;
            wr_ptr_d         = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (push_in && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !push_in) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push_in && !do_pop && (count_q == CNT_W'(DEPTH))));
        end
    end

    assign head_valid_out = (count_q != '0);
    assign head_data_out  = slot_q[rd_ptr_q];
    assign count_out      = count_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_port
// Brief    : Fixed-latency single-port data memory, credit-limited responses.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_port
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LAT        = 2,
    parameter int RESP_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_op_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              resp_valid_out,
    input  logic              resp_ready_in,
    output logic              resp_op_out,
    output logic [DATA_W-1:0] resp_data_out,
    output logic              resp_err_out
);

    localparam int WORDS  = 1 << DEPTH_LOG2;
    localparam int RESP_W = DATA_W + 2;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

    if (LAT < LAT_MIN || LAT > LAT_MAX ||
        RESP_DEPTH < RESP_DEPTH_MIN || RESP_DEPTH > RESP_DEPTH_MAX) begin : g_param_check
        $error("data_mem_port: LAT or RESP_DEPTH outside legal range");
    end

    logic [DATA_W-1:0]     mem_array [WORDS];
    logic                  accept;
    logic                  pop;
    logic                  is_write;
    logic                  out_of_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [DATA_W-1:0]     acc_data;
    logic [RESP_W-1:0]     acc_resp;
    logic                  push_valid;
    logic [RESP_W-1:0]     push_resp;
    logic                  head_valid;
    logic [RESP_W-1:0]     head_resp;
    logic [CNT_W-1:0]      outstanding_d, outstanding_q;
    logic [CNT_W-1:0]      unused_fifo_count;
    logic                  unused_addr_bits;

    assign accept           = req_valid_in && req_ready_out;
    assign pop              = head_valid && resp_ready_in;
    assign is_write         = (mem_op_t'(req_op_in) == MEM_WRITE);
    assign word_idx         = req_addr_in[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^req_addr_in[1:0];

    if (ADDR_W > DEPTH_LOG2 + 2) begin : g_range
        assign out_of_range = |req_addr_in[ADDR_W-1:DEPTH_LOG2+2];
    end else begin : g_no_range
        assign out_of_range = 1'b0;
    end

    // Write responses echo the store data; faulting requests return zero.
    always_comb begin
        acc_data = '0;
        if (!out_of_range) begin
            acc_data = is_write ? req_wdata_in : mem_array[word_idx];
        end
        acc_resp = {req_op_in, out_of_range, acc_data};
    end

    always_ff @(posedge clk) begin
        if (accept && is_write && !out_of_range) begin
            mem_array[word_idx] <= req_wdata_in;
        end
    end

    if (LAT > 1) begin : g_pipe
        localparam int STAGES = LAT - 1;

        logic [STAGES-1:0] stage_valid_d, stage_valid_q;
        logic [RESP_W-1:0] stage_data_d [STAGES];
        logic [RESP_W-1:0] stage_data_q [STAGES];

        always_comb begin
            stage_valid_d    = '0;
            stage_valid_d[0] = accept;
            stage_data_d[0]  = acc_resp;
            for (int i = 1; i < STAGES; i++) begin
                stage_valid_d[i] = stage_valid_q[i-1];
                stage_data_d[i]  = stage_data_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_valid_q <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    stage_data_q[i] <= '0;
                end
            end else begin
                stage_valid_q <= stage_valid_d;
                stage_data_q  <= stage_data_d;
            end
        end

        assign push_valid = stage_valid_q[STAGES-1];
        assign push_resp  = stage_data_q[STAGES-1];
    end else begin : g_no_pipe
        assign push_valid = accept;
        assign push_resp  = acc_resp;
    end

    resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (RESP_DEPTH),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk            (clk),
        .rst            (reset),
        .push_in        (push_valid),
        .push_data_in   (push_resp),
        .pop_in         (pop),
        .head_valid_out (head_valid),
        .head_data_out  (head_resp),
        .count_out      (unused_fifo_count)
    );

    // Credits cover both the latency pipe and the FIFO, so a push always fits.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (pop && !accept) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign req_ready_out  = (outstanding_q < CNT_W'(RESP_DEPTH));
    assign resp_valid_out = head_valid;
    assign resp_op_out    = head_resp[RESP_W-1];
    assign resp_err_out   = head_resp[RESP_W-2];
    assign resp_data_out  = head_resp[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_port
// Brief    : Directed bench with a queue-based reference model of the port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_port;
    import mem_pkg::*;

    localparam int LAT        = 2;
    localparam int RESP_DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_op_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic        resp_ready_in;
    logic        resp_op_out;
    logic [31:0] resp_data_out;
    logic        resp_err_out;

    data_mem_port #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH_LOG2 (10),
        .LAT        (LAT),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_op_in      (req_op_in),
        .req_addr_in    (req_addr_in),
        .req_wdata_in   (req_wdata_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_op_out    (resp_op_out),
        .resp_data_out  (resp_data_out),
        .resp_err_out   (resp_err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        mem_resp_t r;
        int        due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: responses become visible LAT cycles after acceptance,
    // in order, and every accepted-but-unconsumed request holds one credit.
    always @(negedge clk) begin : model
        logic      exp_valid;
        logic      exp_ready;
        mem_resp_t r;
        exp_t      e;
        if (reset) begin
            exp_q.delete();
            check("rst_ready", req_ready_out, 1);
            check("rst_valid", resp_valid_out, 0);
            check("rst_op", resp_op_out, 0);
            check("rst_err", resp_err_out, 0);
            check("rst_data", resp_data_out, 0);
        end else begin
            exp_ready = exp_q.size() < RESP_DEPTH;
            exp_valid = exp_q.size() > 0 && exp_q[0].due <= cyc;
            check("mdl_ready", req_ready_out, exp_ready);
            check("mdl_valid", resp_valid_out, exp_valid);
            if (exp_valid) begin
                check("mdl_op", resp_op_out, exp_q[0].r.op);
                check("mdl_err", resp_err_out, exp_q[0].r.err);
                check("mdl_data", resp_data_out, exp_q[0].r.data);
            end
            if (exp_valid && resp_ready_in) exp_q.pop_front();
            if (exp_ready && req_valid_in) begin
                r.op   = mem_op_t'(req_op_in);
                r.err  = (req_addr_in[31:12] != 20'd0);
                r.data = r.err ? 32'd0 :
                         (req_op_in ? req_wdata_in : model_mem[req_addr_in[11:2]]);
                if (req_op_in && !r.err) model_mem[req_addr_in[11:2]] = req_wdata_in;
                e.r   = r;
                e.due = cyc + LAT;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic op, input logic [31:0] addr, input logic [31:0] wd,
                        output int acc_cyc);
        req_valid_in = 1'b1;
        req_op_in    = op;
        req_addr_in  = addr;
        req_wdata_in = wd;
        acc_cyc      = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready_out) begin
                acc_cyc = cyc;
                break;
            end
        end
        check("send_accepted", acc_cyc >= 0, 1);
        @(posedge clk);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic wait_resp(output int c, output mem_resp_t r);
        c = -1;
        r = '0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (resp_valid_out && resp_ready_in) begin
                c      = cyc;
                r.op   = mem_op_t'(resp_op_out);
                r.err  = resp_err_out;
                r.data = resp_data_out;
                break;
            end
        end
        check("resp_arrived", c >= 0, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int        tw, tr, t, c, n;
        int        acc [16];
        mem_resp_t r;

        reset         = 1'b1;
        req_valid_in  = 1'b0;
        req_op_in     = 1'b0;
        req_addr_in   = '0;
        req_wdata_in  = '0;
        resp_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Write then immediate read-after-write.
        send(1'b1, 32'h10, 32'hDEADBEEF, tw);
        send(1'b0, 32'h10, 32'h0, tr);
        check("raw_accept_gap", tr - tw, 1);
        wait_resp(c, r);
        check("wr_latency", c - tw, 2);
        check("wr_op", r.op, 1);
        check("wr_err", r.err, 0);
        check("wr_data", r.data, 32'hDEADBEEF);
        wait_resp(c, r);
        check("rd_latency", c - tw, 3);
        check("rd_op", r.op, 0);
        check("rd_data", r.data, 32'hDEADBEEF);

        for (int i = 0; i < 16; i++) send(1'b1, 32'(i * 4), 32'hA5A50000 + 32'(i), t);
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) send(1'b0, 32'(i * 4), 32'h0, acc[i]);
        check("stream_one_per_cycle", acc[15] - acc[0], 15);
        repeat (5) @(posedge clk);
        #1;

        // Consumer stalled: credits must cap acceptance at RESP_DEPTH.
        resp_ready_in = 1'b0;
        req_valid_in  = 1'b1;
        req_op_in     = 1'b0;
        req_addr_in   = 32'h8;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready_out) n++;
        end
        @(posedge clk);
        #1;
        req_valid_in = 1'b0;
        check("stall_accepts", n, 3);
        check("stall_ready_low", req_ready_out, 0);
        resp_ready_in = 1'b1;
        @(negedge clk);
        check("first_pop_valid", resp_valid_out, 1);
        check("first_pop_data", resp_data_out, 32'hA5A50002);
        check("ready_in_pop_cycle", req_ready_out, 0);
        @(negedge clk);
        check("ready_after_pop", req_ready_out, 1);
        repeat (4) @(posedge clk);
        #1;

        send(1'b0, 32'h1000, 32'h0, t);
        wait_resp(c, r);
        check("oor_rd_latency", c - t, 2);
        check("oor_rd_err", r.err, 1);
        check("oor_rd_data", r.data, 0);
        send(1'b1, 32'h1000, 32'hBAD0BAD0, t);
        wait_resp(c, r);
        check("oor_wr_op", r.op, 1);
        check("oor_wr_err", r.err, 1);
        check("oor_wr_data", r.data, 0);
        send(1'b0, 32'h0, 32'h0, t);
        wait_resp(c, r);
        check("oor_array_untouched", r.data, 32'hA5A50000);

        // Reset with requests in flight; committed writes must survive.
        send(1'b1, 32'h20, 32'h12345678, t);
        wait_resp(c, r);
        @(posedge clk);
        #1;
        resp_ready_in = 1'b0;
        send(1'b0, 32'h20, 32'h0, t);
        send(1'b0, 32'h24, 32'h0, t);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("inrst_valid", resp_valid_out, 0);
            check("inrst_ready", req_ready_out, 1);
        end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        resp_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_valid", resp_valid_out, 0);
            check("postrst_ready", req_ready_out, 1);
        end
        @(posedge clk);
        #1;
        send(1'b0, 32'h20, 32'h0, t);
        wait_resp(c, r);
        check("postrst_word8", r.data, 32'h12345678);
        send(1'b0, 32'h0C, 32'h0, t);
        wait_resp(c, r);
        check("postrst_word3", r.data, 32'hA5A50003);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
